// File: rtl/swgbe_oflow_monitor.sv
// ---------------------------------------------------------------------------
// swgbe_oflow_monitor
//
// Purpose:
//   Watches the 10GbE TX handshake in the user clock domain and condenses it
//   into a single 32-bit status word for the swgbe_oflow software register.
//   The word carries sticky overflow / almost-full flags, a delayed copy of the
//   live overflow level, a saturation flag and two saturating counters
//   (overflow episodes and dropped words). A stretched overflow pulse is also
//   produced for an LED or GPIO.
//
// Parameters:
//   EVT_W      overflow-episode counter width (EVT_W + DROP_W must be 28)
//   DROP_W     dropped-word counter width
//   LED_CYCLES LED stretch length in user_clk cycles (>= 1)
//
// Ports:
//   user_clk     in   1   sole clock, rising edge
//   user_rst     in   1   asynchronous, active-high reset
//   tx_valid     in   1   word presented to the TX core this cycle
//   tx_overflow  in   1   TX FIFO overflow level
//   tx_afull     in   1   TX FIFO almost-full level
//   clr          in   1   software clear level; only its rising edge acts
//   status_word  out  32  {oflow_sticky, afull_sticky, oflow_now, sat,
//                          evt_cnt[EVT_W-1:0], drop_cnt[DROP_W-1:0]}
//   oflow_led    out  1   stretched overflow indicator
// ---------------------------------------------------------------------------
module swgbe_oflow_monitor #(
  parameter int EVT_W      = 12,
  parameter int DROP_W     = 16,
  parameter int LED_CYCLES = 2**20
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        tx_valid,
  input  logic        tx_overflow,
  input  logic        tx_afull,
  input  logic        clr,
  output logic [31:0] status_word,
  output logic        oflow_led
);

  // The stretch counter only has to hold LED_CYCLES-1.
  localparam int                LED_W    = (LED_CYCLES > 1) ? $clog2(LED_CYCLES) : 1;
  localparam logic [LED_W-1:0]  LED_LOAD = LED_W'(LED_CYCLES - 1);
  localparam logic [EVT_W-1:0]  EVT_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // Saturating increment with clear. On a clear the counter restarts from
  // the increment of the same cycle, so a coincident event is not lost.
  function automatic logic [EVT_W-1:0] evt_next(input logic [EVT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             clear);
    logic [EVT_W-1:0] res;
    res = cnt;
    if (clear) begin
      res = EVT_W'(inc);
    end else if (inc && (cnt != EVT_MAX)) begin
      res = cnt + EVT_W'(1);
    end
    return res;
  endfunction

  function automatic logic [DROP_W-1:0] drop_next(input logic [DROP_W-1:0] cnt,
                                                  input logic              inc,
                                                  input logic              clear);
    logic [DROP_W-1:0] res;
    res = cnt;
    if (clear) begin
      res = DROP_W'(inc);
    end else if (inc && (cnt != DROP_MAX)) begin
      res = cnt + DROP_W'(1);
    end
    return res;
  endfunction

  // Registered state
  logic              r_ovf_q;
  logic              r_clr_q;
  logic              r_oflow_sticky;
  logic              r_afull_sticky;
  logic              r_sat;
  logic [EVT_W-1:0]  r_evt_cnt;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [LED_W-1:0]  r_led_cnt;
  logic              r_led;

  // Next-state terms
  logic              w_ovf_rise;
  logic              w_drop;
  logic              w_clr_rise;
  logic [EVT_W-1:0]  w_evt_nxt;
  logic [DROP_W-1:0] w_drop_nxt;
  logic              w_sat_nxt;
  logic              w_oflow_sticky_nxt;
  logic              w_afull_sticky_nxt;
  logic [LED_W-1:0]  w_led_cnt_nxt;
  logic              w_led_nxt;

  // ovf_q and clr_q reset to 0, so a level already high in the first cycle
  // after reset is seen as a rising edge.
  assign w_ovf_rise = tx_overflow & ~r_ovf_q;
  assign w_drop     = tx_valid & tx_overflow;
  assign w_clr_rise = clr & ~r_clr_q;

  assign w_evt_nxt  = evt_next(r_evt_cnt, w_ovf_rise, w_clr_rise);
  assign w_drop_nxt = drop_next(r_drop_cnt, w_drop, w_clr_rise);

  // sat follows the counters' next values so it rises together with the
  // counter reaching all-ones, and drops on a clear that restarts them.
  assign w_sat_nxt = (r_sat & ~w_clr_rise)
                   | (w_evt_nxt == EVT_MAX)
                   | (w_drop_nxt == DROP_MAX);

  assign w_oflow_sticky_nxt = tx_overflow | (r_oflow_sticky & ~w_clr_rise);
  assign w_afull_sticky_nxt = tx_afull    | (r_afull_sticky & ~w_clr_rise);

  // The LED is lit in the load cycle and for every cycle the counter is still
  // nonzero, giving exactly LED_CYCLES lit cycles; a new rise reloads it.
  always_comb begin
    w_led_cnt_nxt = r_led_cnt;
    if (w_ovf_rise) begin
      w_led_cnt_nxt = LED_LOAD;
    end else if (r_led_cnt != '0) begin
      w_led_cnt_nxt = r_led_cnt - LED_W'(1);
    end
  end

  assign w_led_nxt = w_ovf_rise | (r_led_cnt != '0);

  // Stage boundary: all status and LED state registered on user_clk.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_ovf_q        <= 1'b0;
      r_clr_q        <= 1'b0;
      r_oflow_sticky <= 1'b0;
      r_afull_sticky <= 1'b0;
      r_sat          <= 1'b0;
      r_evt_cnt      <= '0;
      r_drop_cnt     <= '0;
      r_led_cnt      <= '0;
      r_led          <= 1'b0;
    end else begin
      r_ovf_q        <= tx_overflow;
      r_clr_q        <= clr;
      r_oflow_sticky <= w_oflow_sticky_nxt;
      r_afull_sticky <= w_afull_sticky_nxt;
      r_sat          <= w_sat_nxt;
      r_evt_cnt      <= w_evt_nxt;
      r_drop_cnt     <= w_drop_nxt;
      r_led_cnt      <= w_led_cnt_nxt;
      r_led          <= w_led_nxt;
    end
  end

  assign status_word = {r_oflow_sticky, r_afull_sticky, r_ovf_q, r_sat,
                        r_evt_cnt, r_drop_cnt};
  assign oflow_led   = r_led;

endmodule

// File: tb/tb_swgbe_oflow_monitor.sv
module tb_swgbe_oflow_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tv = 1'b0, to = 1'b0, ta = 1'b0, tc = 1'b0;
  logic [31:0] sw0, sw1;
  logic        led0, led1;

  always #5 clk = ~clk;

  // Instance 0: default counter widths, short LED stretch.
  swgbe_oflow_monitor #(.EVT_W(12), .DROP_W(16), .LED_CYCLES(8)) dut (
    .user_clk(clk), .user_rst(rst), .tx_valid(tv), .tx_overflow(to),
    .tx_afull(ta), .clr(tc), .status_word(sw0), .oflow_led(led0));

  // Instance 1: narrow drop counter, single-cycle LED pulse.
  swgbe_oflow_monitor #(.EVT_W(24), .DROP_W(4), .LED_CYCLES(1)) dut_s (
    .user_clk(clk), .user_rst(rst), .tx_valid(tv), .tx_overflow(to),
    .tx_afull(ta), .clr(tc), .status_word(sw1), .oflow_led(led1));

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int EMAX [2] = '{4095, 16777215};
  int DMAX [2] = '{65535, 15};
  int LEDN [2] = '{8, 1};
  int DW   [2] = '{16, 4};

  int m_evt [2];
  int m_drop[2];
  int m_left[2];   // remaining lit cycles of the LED
  bit m_os  [2];
  bit m_as  [2];
  bit m_sat [2];
  bit m_lout[2];
  bit m_pov;       // overflow level seen last cycle
  bit m_pclr;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_evt[k] = 0; m_drop[k] = 0; m_left[k] = 0;
      m_os[k] = 0; m_as[k] = 0; m_sat[k] = 0; m_lout[k] = 0;
    end
    m_pov = 0; m_pclr = 0;
  endtask

  task automatic model_step(input bit v, input bit o, input bit a, input bit c);
    bit rise, crise, drp;
    rise  = o && !m_pov;
    crise = c && !m_pclr;
    drp   = v && o;
    for (int k = 0; k < 2; k++) begin
      if (crise) begin
        m_evt[k]  = rise ? 1 : 0;
        m_drop[k] = drp ? 1 : 0;
        m_os[k]   = o;
        m_as[k]   = a;
        m_sat[k]  = 0;
      end else begin
        if (rise) m_evt[k]  = (m_evt[k]  + 1 > EMAX[k]) ? EMAX[k] : m_evt[k] + 1;
        if (drp)  m_drop[k] = (m_drop[k] + 1 > DMAX[k]) ? DMAX[k] : m_drop[k] + 1;
        m_os[k] = m_os[k] || o;
        m_as[k] = m_as[k] || a;
      end
      m_sat[k] = m_sat[k] || (m_evt[k] == EMAX[k]) || (m_drop[k] == DMAX[k]);
      if (rise) m_left[k] = LEDN[k];
      m_lout[k] = (m_left[k] > 0);
      if (m_left[k] > 0) m_left[k]--;
    end
    m_pov  = o;
    m_pclr = c;
  endtask

  function automatic logic [31:0] model_word(input int k);
    logic [31:0] w;
    w = (32'(m_os[k]) << 31) | (32'(m_as[k]) << 30) | (32'(m_pov) << 29) |
        (32'(m_sat[k]) << 28) | (32'(m_evt[k]) << DW[k]) | 32'(m_drop[k]);
    return w;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the clock and compares both
  // instances against the model 1 ns after the edge.
  task automatic step(input bit v, input bit o, input bit a, input bit c);
    tv = v; to = o; ta = a; tc = c;
    @(posedge clk);
    #1;
    model_step(v, o, a, c);
    chk("model_status0", sw0, model_word(0));
    chk("model_status1", sw1, model_word(1));
    chk("model_led0", 32'(led0), 32'(m_lout[0]));
    chk("model_led1", 32'(led1), 32'(m_lout[1]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tv = 0; to = 0; ta = 0; tc = 0;
    #2;
    chk("reset_status0", sw0, 32'h0);
    chk("reset_status1", sw1, 32'h0);
    chk("reset_led0", 32'(led0), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit          v, o, a, c;
    logic [31:0] sw;
    logic        led;
  } vec_t;

  vec_t tbl[12];

  initial begin
    bit po;
    // Overflow burst (5 cycles, 3 valid), afull, then clear coincident with
    // a new overflow rise and a valid word.
    tbl[0]  = '{1, 1, 0, 0, 32'hA001_0001, 1'b1};
    tbl[1]  = '{1, 1, 0, 0, 32'hA001_0002, 1'b1};
    tbl[2]  = '{0, 1, 0, 0, 32'hA001_0002, 1'b1};
    tbl[3]  = '{1, 1, 0, 0, 32'hA001_0003, 1'b1};
    tbl[4]  = '{0, 1, 0, 0, 32'hA001_0003, 1'b1};
    tbl[5]  = '{0, 0, 0, 0, 32'h8001_0003, 1'b1};
    tbl[6]  = '{0, 0, 1, 0, 32'hC001_0003, 1'b1};
    tbl[7]  = '{0, 0, 0, 0, 32'hC001_0003, 1'b1};
    tbl[8]  = '{0, 0, 0, 0, 32'hC001_0003, 1'b0};
    tbl[9]  = '{1, 1, 0, 1, 32'hA001_0001, 1'b1};
    tbl[10] = '{0, 0, 0, 1, 32'h8001_0001, 1'b1};
    tbl[11] = '{0, 0, 0, 0, 32'h8001_0001, 1'b1};

    model_reset();
    #1;

    // Reset and idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      chk("idle_status", sw0, 32'h0);
      chk("idle_led", 32'(led0), 32'h0);
    end

    // Table vectors
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].o, tbl[i].a, tbl[i].c);
      chk($sformatf("tbl%0d_status", i), sw0, tbl[i].sw);
      chk($sformatf("tbl%0d_led", i), 32'(led0), 32'(tbl[i].led));
    end

    // Three separate overflow pulses, then clr held high
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    chk("three_pulses_evt", 32'(sw0[27:16]), 32'd3);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      chk("clr_held_status", sw0, 32'h0);
    end
    step(0, 1, 0, 1);
    chk("clr_held_no_reclear", sw0, 32'hA001_0000);
    step(0, 0, 0, 1);
    chk("clr_held_keep", sw0, 32'h8001_0000);
    step(0, 0, 0, 0);

    // Narrow drop counter saturation and clear
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
    chk("drop_sat_status", sw1, 32'hB000_001F);
    chk("drop_wide_status", sw0, 32'hA001_0014);
    step(0, 0, 0, 1);
    chk("drop_sat_cleared", sw1, 32'h0);
    step(0, 0, 0, 0);

    // LED stretch, retrigger, async reset mid-stretch
    do_reset();
    step(0, 1, 0, 0);
    chk("led_load", 32'(led0), 32'h1);
    chk("led1_pulse", 32'(led1), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0);
      chk($sformatf("led_stretch_k%0d", k), 32'(led0), 32'(k <= 7));
    end
    step(0, 1, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      step(0, (k == 5), 0, 0);
      chk($sformatf("led_retrig_k%0d", k), 32'(led0), 32'(k <= 12));
    end
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led0), 32'h0);
    chk("async_rst_status0", sw0, 32'h0);
    chk("async_rst_status1", sw1, 32'h0);
    model_reset();
    #1;
    rst = 1'b0;
    step(1, 1, 0, 0);
    chk("post_rst_first_rise", sw0, 32'hA001_0001);

    // Event counter saturation
    do_reset();
    for (int i = 0; i < 8200; i++) step(0, (i % 2 == 0), 0, 0);
    chk("evt_sat_cnt", 32'(sw0[27:16]), 32'hFFF);
    chk("evt_sat_flag", 32'(sw0[28]), 32'h1);
    step(0, 0, 0, 1);
    chk("evt_sat_cleared", sw0, 32'h0);
    step(0, 0, 0, 0);

    // Randomized traffic against the model
    do_reset();
    po = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rv, ro, ra, rc;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        po = 0;
      end
      rv = ($urandom_range(0, 1) == 1);
      ro = ($urandom_range(0, 3) == 0) ? !po : po;
      ra = ($urandom_range(0, 7) == 0);
      rc = ($urandom_range(0, 15) == 0) ? !tc : tc;
      po = ro;
      step(rv, ro, ra, rc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
